coincidence_unit_param: RTL
===========================

COINCIDENCE_UNIT_PARAM -- requirements
Module: coincidence_unit_param

Interface
REQ-001 Parameter MC_LEN, default 36: pulse intervals (clk cycles) per minor cycle; even, >= 4.
REQ-002 Parameter NUM_MC, default 16: minor cycles per tank revolution; power of 2, >= 2.
REQ-003 Parameter RP_DELAY, default 36: cycles from first gate cycle to r_pulse; >= MC_LEN.
REQ-004 Derived constants: SHORT_LEN = MC_LEN/2; REV_LEN = NUM_MC*MC_LEN; ADDR_W = $clog2(NUM_MC)+1.
REQ-005 Port clk, input, 1: single clock; one cycle = one pulse interval.
REQ-006 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 Port sync, input, 1: high marks the current cycle as position 0 (minor cycle 0, pulse 0).
REQ-008 Port start, input, 1: stimulating pulse; request accepted only when busy is low.
REQ-009 Port addr, input, ADDR_W: word address; addr[ADDR_W-1:1] is the minor cycle, addr[0] is the half.
REQ-010 Port long_word, input, 1: 1 = long word (full minor cycle), 0 = short word (half).
REQ-011 Port busy, output, 1: request in progress.
REQ-012 Port gate_pos, output, 1: high for exactly the selected word's pulse positions.
REQ-013 Port gate_neg, output, 1: always the complement of gate_pos.
REQ-014 Port r_pulse, output, 1: one-cycle end-of-transfer pulse to the main control.
REQ-015 Port cur_mc, output, ADDR_W-1: current minor-cycle count (debug/observation).

Function
REQ-016 The timebase SHALL hold position P in 0..REV_LEN-1, advancing by 1 per cycle and wrapping REV_LEN-1 -> 0.
REQ-017 When sync is high in cycle T, cycle T SHALL be position 0 and T+1 position 1, overriding the count.
REQ-018 Target start S SHALL be addr_mc*MC_LEN + (long_word ? 0 : addr[0]*SHORT_LEN); addr[0] is ignored for long words.
REQ-019 Word length L SHALL be MC_LEN for long words and SHORT_LEN for short words.
REQ-020 On start with busy low, addr and long_word SHALL be captured and the FSM SHALL move IDLE -> ARMED; busy SHALL be high from the next cycle.
REQ-021 In ARMED, gate_pos SHALL rise in the first cycle after capture whose position equals S, so the wait is 1..REV_LEN cycles.
REQ-022 If the capture cycle itself is at position S, the gate SHALL wait one full revolution.
REQ-023 In GATE, gate_pos SHALL stay high for exactly L consecutive cycles, then the FSM SHALL enter WAIT_R.
REQ-024 r_pulse SHALL be high exactly RP_DELAY cycles after the first gate cycle; the FSM SHALL then return to IDLE and busy SHALL be low in the following cycle.
REQ-025 start while busy is high SHALL be ignored, with no queuing.
REQ-026 sync during ARMED SHALL realign position; matching SHALL continue against the realigned position.
REQ-027 sync during GATE or WAIT_R SHALL NOT shorten or lengthen the gate or r_pulse timing.
REQ-028 FSM states SHALL be exactly IDLE, ARMED, GATE and WAIT_R; an illegal state encoding SHALL go to IDLE.

Reset
REQ-029 While rst_n is low at a clk edge: FSM = IDLE, position = 0, busy = 0, gate_pos = 0, gate_neg = 1, r_pulse = 0, cur_mc = 0, captured request cleared.
REQ-030 Reset mid-operation SHALL abort the request with no r_pulse.
REQ-031 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from inputs to outputs.

Structure
REQ-032 Package edsac_cu_pkg SHALL hold the FSM state enum and the default MC_LEN, NUM_MC and RP_DELAY constants.
REQ-033 Sub-module cu_timebase SHALL implement the pulse and minor-cycle counters with sync realignment, outputting position and cur_mc.

Verification (defaults, sync at cycle T)
REQ-034 Short word: start at T+10 with addr=5, long_word=0 -> gate_pos high T+90..T+107 (18 cycles); r_pulse only at T+126; busy low from T+127.
REQ-035 Long word: start at T+10 with addr=4, long_word=1 -> gate_pos high T+72..T+107 (36 cycles); r_pulse at T+108.
REQ-036 Wrap and boundary, addr=5 short:
  - start at T+89 -> gate starts at T+90;
  - start at T+90 -> gate starts at T+666;
  - start at T+91 -> gate starts at T+666.
REQ-037 Busy and resync: second start at T+20 while busy is ignored (single gate, single r_pulse); sync re-asserted at T+50 in ARMED -> gate for addr=5 starts at T+140.
REQ-038 rst_n low at T+95 during GATE -> from T+96 gate_pos = 0, gate_neg = 1, busy = 0, and r_pulse never fires; gate_neg == ~gate_pos is checked every cycle.

Source files
------------

// File: rtl/edsac_cu_pkg.sv
// Shared definitions for the EDSAC-style coincidence unit.
//
// Holds the controller state encoding and the default timing constants used
// by coincidence_unit_param and cu_timebase.
//   DefaultMcLen   : pulse intervals per minor cycle
//   DefaultNumMc   : minor cycles per tank revolution
//   DefaultRpDelay : cycles from the first gate cycle to the end-of-transfer pulse
package edsac_cu_pkg;

    localparam int unsigned DefaultMcLen   = 36;
    localparam int unsigned DefaultNumMc   = 16;
    localparam int unsigned DefaultRpDelay = 36;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StGate  = 2'd2,
        StWaitR = 2'd3
    } cu_state_e;

endpackage

// File: rtl/cu_timebase.sv
// Tank timebase: pulse-within-minor-cycle counter and minor-cycle counter.
//
// The current cycle's position is (mc_q, pulse_q) unless sync_i is high, in
// which case the current cycle is forced to position 0. The position of the
// following cycle is presented on pulse_next_o / mc_next_o so the controller
// can register its gate to coincide with that position.
//
// Ports
//   clk_i        : clock, one cycle per pulse interval
//   rst_ni       : synchronous active-low reset
//   sync_i       : marks the current cycle as position 0
//   pulse_next_o : pulse index of the next cycle
//   mc_next_o    : minor-cycle index of the next cycle
//   cur_mc_o     : registered minor-cycle count of the current cycle
module cu_timebase
    import edsac_cu_pkg::*;
#(
    parameter int unsigned MC_LEN = DefaultMcLen,
    parameter int unsigned NUM_MC = DefaultNumMc,
    localparam int unsigned PulseW = $clog2(MC_LEN),
    localparam int unsigned McW    = $clog2(NUM_MC)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sync_i,
    output logic [PulseW-1:0] pulse_next_o,
    output logic [McW-1:0]    mc_next_o,
    output logic [McW-1:0]    cur_mc_o
);

    logic [PulseW-1:0] pulse_q;
    logic [PulseW-1:0] pulse_eff;
    logic [McW-1:0]    mc_q;
    logic [McW-1:0]    mc_eff;

    // NUM_MC is a power of two, so the minor-cycle count wraps on its own.
    always_comb begin
        pulse_eff = sync_i ? '0 : pulse_q;
        mc_eff    = sync_i ? '0 : mc_q;
        if (pulse_eff == PulseW'(MC_LEN - 1)) begin
            pulse_next_o = '0;
            mc_next_o    = mc_eff + McW'(1);
        end else begin
            pulse_next_o = pulse_eff + PulseW'(1);
            mc_next_o    = mc_eff;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pulse_q <= '0;
            mc_q    <= '0;
        end else begin
            pulse_q <= pulse_next_o;
            mc_q    <= mc_next_o;
        end
    end

    assign cur_mc_o = mc_q;

endmodule

// File: rtl/coincidence_unit_param.sv
// Coincidence unit: opens a store gate for exactly one addressed word as it
// passes through the delay-line tank, then signals end of transfer.
//
// A request (addr, long_word) is captured on start while idle. The gate is
// raised in the first cycle after capture whose tank position equals the
// word's start position, held for the word length, and r_pulse fires a fixed
// RP_DELAY cycles after the first gate cycle.
//
// Ports
//   clk       : clock, one cycle per pulse interval
//   rst_n     : synchronous active-low reset
//   sync      : marks the current cycle as tank position 0
//   start     : request strobe, honoured only while busy is low
//   addr      : word address; upper bits minor cycle, bit 0 half-word select
//   long_word : 1 selects a full minor cycle, 0 a half
//   busy      : request in progress
//   gate_pos  : high during the selected word's pulse positions
//   gate_neg  : complement of gate_pos
//   r_pulse   : one-cycle end-of-transfer pulse
//   cur_mc    : current minor-cycle count
module coincidence_unit_param
    import edsac_cu_pkg::*;
#(
    parameter int unsigned MC_LEN   = DefaultMcLen,
    parameter int unsigned NUM_MC   = DefaultNumMc,
    parameter int unsigned RP_DELAY = DefaultRpDelay,
    localparam int unsigned SHORT_LEN = MC_LEN / 2,
    localparam int unsigned ADDR_W    = $clog2(NUM_MC) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              long_word,
    output logic              busy,
    output logic              gate_pos,
    output logic              gate_neg,
    output logic              r_pulse,
    output logic [ADDR_W-2:0] cur_mc
);

    localparam int unsigned PulseW = $clog2(MC_LEN);
    localparam int unsigned McW    = ADDR_W - 1;
    localparam int unsigned CntW   = $clog2(RP_DELAY + 1);

    localparam logic [CntW-1:0] LongLast  = CntW'(MC_LEN - 1);
    localparam logic [CntW-1:0] ShortLast = CntW'(SHORT_LEN - 1);
    localparam logic [CntW-1:0] RpLast    = CntW'(RP_DELAY - 1);

    cu_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              long_q;
    logic [CntW-1:0]   cnt_q;      // cycles since the first gate cycle
    logic              gate_q;
    logic              r_pulse_q;

    logic [PulseW-1:0] pulse_next;
    logic [McW-1:0]    mc_next;
    logic              hit_in;
    logic              hit_tgt;
    logic [CntW-1:0]   gate_last;

    cu_timebase #(
        .MC_LEN (MC_LEN),
        .NUM_MC (NUM_MC)
    ) u_timebase (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sync_i       (sync),
        .pulse_next_o (pulse_next),
        .mc_next_o    (mc_next),
        .cur_mc_o     (cur_mc)
    );

    // Pulse index at which a word begins; the half select only applies to short words.
    function automatic logic [PulseW-1:0] word_pulse(input logic half, input logic long_w);
        return (half && !long_w) ? PulseW'(SHORT_LEN) : '0;
    endfunction

    // Matching is against the next cycle's position so the gate register rises
    // exactly in the cycle whose position equals the word start.
    assign hit_in  = (mc_next == addr[ADDR_W-1:1]) &&
                     (pulse_next == word_pulse(addr[0], long_word));
    assign hit_tgt = (mc_next == addr_q[ADDR_W-1:1]) &&
                     (pulse_next == word_pulse(addr_q[0], long_q));

    assign gate_last = long_q ? LongLast : ShortLast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            long_q    <= 1'b0;
            cnt_q     <= '0;
            gate_q    <= 1'b0;
            r_pulse_q <= 1'b0;
        end else begin
            r_pulse_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q <= addr;
                        long_q <= long_word;
                        cnt_q  <= '0;
                        // Word starts in the very next cycle: the armed wait is
                        // zero cycles long, so go straight to the gate.
                        if (hit_in) begin
                            state_q <= StGate;
                            gate_q  <= 1'b1;
                        end else begin
                            state_q <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (hit_tgt) begin
                        state_q <= StGate;
                        gate_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StGate: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == gate_last) begin
                        gate_q  <= 1'b0;
                        state_q <= StWaitR;
                    end
                    // Only reachable when the word length equals RP_DELAY.
                    if (cnt_q == RpLast) begin
                        r_pulse_q <= 1'b1;
                    end
                end
                StWaitR: begin
                    // Stay busy through the r_pulse cycle, then release.
                    if (r_pulse_q) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == RpLast) begin
                            r_pulse_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    gate_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state_q != StIdle);
    assign gate_pos = gate_q;
    assign gate_neg = ~gate_q;
    assign r_pulse  = r_pulse_q;

endmodule
